// File: rtl/issue_window_ctrl_pkg.sv
// Shared definitions for the in-order issue window: packet type, widths, NOP packet.
// Optional feature macro used by this slice: ISSUE_PERF_EN.
package issue_window_ctrl_pkg;

    localparam int unsigned ISSUE_WIDTH = 3;
    localparam int unsigned ROLLBACK_W  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ID_EX_PACKET;

    localparam ID_EX_PACKET NOP_PACKET = '0;

    function automatic logic [ROLLBACK_W-1:0] popcount(input logic [ISSUE_WIDTH-1:0] v);
        logic [ROLLBACK_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            s = s + ROLLBACK_W'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/issue_window_ctrl_if.sv
// Decode / detection-unit facing signal bundle of the issue window.
// master = decode/detection side, slave = the window itself.
interface issue_window_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    import issue_window_ctrl_pkg::*;

    logic                           squash;
    logic                           ex_stall;
    ID_EX_PACKET                    dec_packet_0;
    ID_EX_PACKET                    dec_packet_1;
    ID_EX_PACKET                    dec_packet_2;
    logic [ISSUE_WIDTH-1:0]         dec_valid;
    logic                           dec_ready;
    ID_EX_PACKET                    id_packet_out_0;
    ID_EX_PACKET                    id_packet_out_1;
    ID_EX_PACKET                    id_packet_out_2;
    logic [ISSUE_WIDTH-1:0]         id_valid_out;
    logic [ROLLBACK_W-1:0]          rollback;
    logic [ISSUE_WIDTH-1:0]         issue_valid;
    logic [$clog2(DEPTH):0]         entry_count;
    logic [31:0]                    perf_issued;
    logic [31:0]                    perf_hazard_cyc;

    modport master (
        output squash, ex_stall, dec_packet_0, dec_packet_1, dec_packet_2, dec_valid, rollback,
        input  dec_ready, id_packet_out_0, id_packet_out_1, id_packet_out_2, id_valid_out,
               issue_valid, entry_count, perf_issued, perf_hazard_cyc
    );

    modport slave (
        input  squash, ex_stall, dec_packet_0, dec_packet_1, dec_packet_2, dec_valid, rollback,
        output dec_ready, id_packet_out_0, id_packet_out_1, id_packet_out_2, id_valid_out,
               issue_valid, entry_count, perf_issued, perf_hazard_cyc
    );

endinterface

// File: rtl/issue_window_ctrl_ring_buf.sv
// DEPTH-entry circular packet store: up to WIDTH writes at wr_ptr, WIDTH reads at rd_ptr.
// Pointers and occupancy are owned by issue_window_ctrl.
module issue_ring_buf
    import issue_window_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = ISSUE_WIDTH
) (
    input  logic                           clock,
    input  logic [$clog2(DEPTH)-1:0]       wr_ptr,
    input  logic [WIDTH-1:0]               wr_en,
    input  ID_EX_PACKET [WIDTH-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0]       rd_ptr,
    output ID_EX_PACKET [WIDTH-1:0]        rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ID_EX_PACKET mem_q [DEPTH];

    // Storage needs no reset: unoccupied entries are never presented as valid.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_ptr + PTR_W'(i)] <= wr_data[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rd_data[i] = mem_q[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/issue_window_ctrl.sv
// In-order issue window between decode and ID/EX hazard detection (3-wide).
// Optional performance counters enabled by defining ISSUE_PERF_EN.
module issue_window_ctrl
    import issue_window_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    issue_window_ctrl_if.slave bus
);

    localparam int unsigned WIDTH = ISSUE_WIDTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]        head_q, head_d;
    logic [PTR_W-1:0]        tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [WIDTH-1:0]        id_valid;
    logic [WIDTH-1:0]        issue_mask;
    logic [WIDTH-1:0]        wr_en;
    logic [ROLLBACK_W-1:0]   pop;
    logic [ROLLBACK_W-1:0]   push;
    logic                    dec_ready;
    logic                    accept;
    ID_EX_PACKET [WIDTH-1:0] wr_data;
    ID_EX_PACKET [WIDTH-1:0] rd_data;
    ID_EX_PACKET [WIDTH-1:0] present;

    assign wr_data = {bus.dec_packet_2, bus.dec_packet_1, bus.dec_packet_0};

    issue_ring_buf #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ring (
        .clock   (clock),
        .wr_ptr  (tail_q),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_ptr  (head_q),
        .rd_data (rd_data)
    );

    // Ready depends only on registered occupancy, never on rollback/ex_stall.
    assign dec_ready = reset & ((CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH));
    assign accept    = dec_ready & ~bus.squash;
    assign wr_en     = bus.dec_valid & {WIDTH{accept}};

    always_comb begin
        id_valid   = '0;
        issue_mask = '0;
        present    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            id_valid[i]   = (count_q > CNT_W'(i));
            present[i]    = id_valid[i] ? rd_data[i] : NOP_PACKET;
            issue_mask[i] = id_valid[i] & ((i + 32'(bus.rollback)) < WIDTH)
                            & ~bus.ex_stall & ~bus.squash;
        end
    end

    always_comb begin
        pop     = popcount(issue_mask);
        push    = popcount(wr_en);
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (bus.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.dec_ready       = dec_ready;
    assign bus.id_valid_out    = id_valid;
    assign bus.issue_valid     = issue_mask;
    assign bus.entry_count     = count_q;
    assign bus.id_packet_out_0 = present[0];
    assign bus.id_packet_out_1 = present[1];
    assign bus.id_packet_out_2 = present[2];

`ifdef ISSUE_PERF_EN
    logic        hazard;
    logic [31:0] perf_issued_q;
    logic [31:0] perf_hazard_q;

    // A hazard cycle: some real entry was held back by rollback while EX was free.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (((i + 32'(bus.rollback)) >= WIDTH) && id_valid[i]) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & (bus.rollback != '0) & ~bus.ex_stall;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issued_q <= '0;
            perf_hazard_q <= '0;
        end else begin
            perf_issued_q <= perf_issued_q + 32'(pop);
            if (hazard) begin
                perf_hazard_q <= perf_hazard_q + 32'd1;
            end
        end
    end

    assign bus.perf_issued     = perf_issued_q;
    assign bus.perf_hazard_cyc = perf_hazard_q;
`else
    assign bus.perf_issued     = '0;
    assign bus.perf_hazard_cyc = '0;
`endif

    thermometer_dec_valid: assert property (
        @(posedge clock) disable iff (!reset)
        ((bus.dec_valid & (bus.dec_valid + 3'd1)) == 3'd0)
    );

endmodule

// File: tb/tb_issue_window_ctrl.sv
// Directed self-checking bench for issue_window_ctrl (DEPTH=8).
module tb_issue_window_ctrl;
    import issue_window_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    issue_window_ctrl_if #(.DEPTH(8)) bus ();

    issue_window_ctrl #(.DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ID_EX_PACKET mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [11:0] imm);
        ID_EX_PACKET p;
        p.pc   = pc;
        p.inst = {imm, rs1, 3'b000, rd, 7'h13};
        return p;
    endfunction

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef ISSUE_PERF_EN
        return v;
`else
        return v & 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input ID_EX_PACKET p0, input ID_EX_PACKET p1,
                         input ID_EX_PACKET p2, input logic [2:0] v);
        bus.dec_packet_0 = p0;
        bus.dec_packet_1 = p1;
        bus.dec_packet_2 = p2;
        bus.dec_valid    = v;
    endtask

    ID_EX_PACKET a0, a1, a2, b0, b1, b2, c0, c1, c2, g0, g1, g2;
    ID_EX_PACKET exp_q [$];
    int n;

    initial begin
        a0 = mk(32'h0,  5'd1, 5'd1, 12'd1);   // addi x1,x1,1 = 0x00108093
        a1 = mk(32'h4,  5'd2, 5'd1, 12'd1);   // addi x2,x1,1
        a2 = mk(32'h8,  5'd3, 5'd3, 12'd3);   // addi x3,x3,3
        b0 = mk(32'hC,  5'd4, 5'd0, 12'd4);
        b1 = mk(32'h10, 5'd5, 5'd0, 12'd5);
        b2 = mk(32'h14, 5'd6, 5'd0, 12'd6);
        c0 = mk(32'h18, 5'd7, 5'd0, 12'd7);
        c1 = mk(32'h1C, 5'd8, 5'd0, 12'd8);
        c2 = mk(32'h20, 5'd9, 5'd0, 12'd9);

        bus.squash   = 1'b0;
        bus.ex_stall = 1'b0;
        bus.rollback = 2'd0;
        drive(a0, a1, a2, 3'b111);

        // Reset held with a full group offered
        #3;
        chk("a0_enc", 64'(a0.inst), 64'h00108093);
        chk("rst_dec_ready", 64'(bus.dec_ready), 64'd0);
        chk("rst_id_valid", 64'(bus.id_valid_out), 64'd0);
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_perf_issued", 64'(bus.perf_issued), 64'd0);
        bus.dec_valid = 3'b000;
        reset = 1'b1;
        #1;
        chk("rel_dec_ready", 64'(bus.dec_ready), 64'd1);
        chk("rel_count", 64'(bus.entry_count), 64'd0);
        tick();

        // Fill under ex_stall
        bus.ex_stall = 1'b1;
        drive(a0, a1, a2, 3'b111);
        tick();
        chk("fill1_count", 64'(bus.entry_count), 64'd3);
        chk("fill1_id_valid", 64'(bus.id_valid_out), 64'b111);
        chk("fill1_stall_issue", 64'(bus.issue_valid), 64'd0);
        chk("fill1_slot0", bus.id_packet_out_0, a0);
        chk("fill1_ready", 64'(bus.dec_ready), 64'd1);
        drive(b0, b1, b2, 3'b111);
        tick();
        chk("fill2_count", 64'(bus.entry_count), 64'd6);
        chk("fill2_ready", 64'(bus.dec_ready), 64'd0);
        drive(c0, c1, c2, 3'b111);
        tick();
        chk("fill3_held_count", 64'(bus.entry_count), 64'd6);
        chk("fill3_slot2", bus.id_packet_out_2, a2);

        // Partial issue, rollback=2
        bus.dec_valid = 3'b000;
        bus.ex_stall  = 1'b0;
        bus.rollback  = 2'd2;
        #1;
        chk("part_issue", 64'(bus.issue_valid), 64'b001);
        tick();
        bus.rollback = 2'd3;
        #1;
        chk("part_slot0", bus.id_packet_out_0, a1);
        chk("part_count", 64'(bus.entry_count), 64'd5);
        chk("part_ready", 64'(bus.dec_ready), 64'd1);

        // Load-use: rollback=3 for two cycles
        chk("lu1_issue", 64'(bus.issue_valid), 64'd0);
        tick();
        #1;
        chk("lu2_issue", 64'(bus.issue_valid), 64'd0);
        chk("lu2_slot0", bus.id_packet_out_0, a1);
        chk("lu2_slot1", bus.id_packet_out_1, a2);
        chk("lu2_slot2", bus.id_packet_out_2, b0);
        chk("lu2_count", 64'(bus.entry_count), 64'd5);
        tick();
        bus.rollback = 2'd0;
        #1;
        chk("lu_release_issue", 64'(bus.issue_valid), 64'b111);
        chk("lu_slot2", bus.id_packet_out_2, b0);
        chk("lu_hazard", 64'(bus.perf_hazard_cyc), 64'(perf(32'd3)));
        chk("lu_issued", 64'(bus.perf_issued), 64'(perf(32'd1)));
        tick();
        chk("lu_after_count", 64'(bus.entry_count), 64'd2);
        chk("lu_after_issued", 64'(bus.perf_issued), 64'(perf(32'd4)));

        // Wrap: 10 cycles of push 3 / issue up to 3, order checked against a queue
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        for (int k = 0; k < 10; k++) begin
            g0 = mk(32'h100 + 32'(12 * k),     5'(3 * k),     5'd0, 12'(3 * k));
            g1 = mk(32'h100 + 32'(12 * k + 4), 5'(3 * k + 1), 5'd0, 12'(3 * k + 1));
            g2 = mk(32'h100 + 32'(12 * k + 8), 5'(3 * k + 2), 5'd0, 12'(3 * k + 2));
            drive(g0, g1, g2, 3'b111);
            #1;
            n = (exp_q.size() > 3) ? 3 : exp_q.size();
            chk("wrap_issue", 64'(bus.issue_valid), 64'((1 << n) - 1));
            if (n > 0) chk("wrap_slot0", bus.id_packet_out_0, exp_q[0]);
            if (n > 1) chk("wrap_slot1", bus.id_packet_out_1, exp_q[1]);
            if (n > 2) chk("wrap_slot2", bus.id_packet_out_2, exp_q[2]);
            tick();
            for (int j = 0; j < n; j++) void'(exp_q.pop_front());
            exp_q.push_back(g0);
            exp_q.push_back(g1);
            exp_q.push_back(g2);
        end
        chk("wrap_count", 64'(bus.entry_count), 64'd3);
        chk("wrap_issued", 64'(bus.perf_issued), 64'(perf(32'd33)));

        // Squash with a push in the same cycle
        drive(c0, c1, c2, 3'b111);
        bus.squash = 1'b1;
        #1;
        chk("sq_issue", 64'(bus.issue_valid), 64'd0);
        tick();
        bus.squash    = 1'b0;
        bus.dec_valid = 3'b000;
        #1;
        chk("sq_count", 64'(bus.entry_count), 64'd0);
        chk("sq_id_valid", 64'(bus.id_valid_out), 64'd0);
        chk("sq_zero_pkt", bus.id_packet_out_0, 64'd0);
        chk("sq_ready", 64'(bus.dec_ready), 64'd1);
        chk("sq_issued_kept", 64'(bus.perf_issued), 64'(perf(32'd33)));

        // Fill to DEPTH, then a full window still issues
        bus.ex_stall = 1'b1;
        drive(a0, a1, a2, 3'b111);
        tick();
        drive(b0, b1, b2, 3'b011);
        tick();
        chk("full5_ready", 64'(bus.dec_ready), 64'd1);
        drive(c0, c1, c2, 3'b111);
        tick();
        chk("full_count", 64'(bus.entry_count), 64'd8);
        chk("full_ready", 64'(bus.dec_ready), 64'd0);
        bus.dec_valid = 3'b000;
        bus.ex_stall  = 1'b0;
        bus.rollback  = 2'd1;
        #1;
        chk("full_issue", 64'(bus.issue_valid), 64'b011);
        tick();
        chk("full_after_count", 64'(bus.entry_count), 64'd6);
        chk("full_after_slot0", bus.id_packet_out_0, a2);
        chk("full_hazard", 64'(bus.perf_hazard_cyc), 64'(perf(32'd4)));
        chk("full_issued", 64'(bus.perf_issued), 64'(perf(32'd35)));

        // Asynchronous reset mid-operation
        reset = 1'b0;
        #1;
        chk("mid_rst_count", 64'(bus.entry_count), 64'd0);
        chk("mid_rst_id_valid", 64'(bus.id_valid_out), 64'd0);
        chk("mid_rst_issue", 64'(bus.issue_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.dec_ready), 64'd0);
        chk("mid_rst_hazard", 64'(bus.perf_hazard_cyc), 64'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_count", 64'(bus.entry_count), 64'd0);
        chk("post_rst_ready", 64'(bus.dec_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
